// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: active-low hex pattern table, blank code, scan FSM states
// and helpers for the active-low one-hot digit select.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low patterns, bit0 = segment a ... bit6 = segment g, index = hex value.
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } seg_scan_st_t;

    function automatic logic [2:0] onehot_low_idx(input logic [7:0] an_n);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = an_n[i] ? idx : 3'(i);
        end
        return idx;
    endfunction

    function automatic logic onehot_low_ok(input logic [7:0] an_n);
        logic [3:0] zeros;
        zeros = 4'd0;
        for (int i = 0; i < 8; i++) begin
            zeros = zeros + {3'd0, ~an_n[i]};
        end
        return (zeros == 4'd1);
    endfunction

endpackage

// File: rtl/seg_pat_decode.sv
// Combinational active-low 7-segment pattern decoder: flags legal hex codes and the blank code.
module seg_pat_decode
    import seg_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       legal_o,
    output logic       blank_o,
    output logic [3:0] hex_o
);

    // Table lookup against the shared encoder patterns.
    always_comb begin
        legal_o = 1'b0;
        hex_o   = 4'h0;
        blank_o = (seg_i == SEG_BLANK);
        for (int h = 0; h < 16; h++) begin
            legal_o = legal_o | (seg_i == SEG_HEX[h]);
            hex_o   = (seg_i == SEG_HEX[h]) ? 4'(h) : hex_o;
        end
    end

endmodule

// File: rtl/seg_scan_decode.sv
// Multiplexed 7-segment bus readback: debounces each scanned digit and decodes it to hex.
// Optional decimal point readback is enabled by defining SEG_SCAN_DP_EN.
module seg_scan_decode
    import seg_pkg::*;
#(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        seg_i,
    input  logic [NDIG-1:0]   an_i,
`ifdef SEG_SCAN_DP_EN
    input  logic              dp_i,
    output logic [NDIG-1:0]   dp_o,
`endif
    output logic [4*NDIG-1:0] digits_o,
    output logic [NDIG-1:0]   valid_o,
    output logic              upd_o,
    output logic              err_o
);

    localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYC);

    logic [6:0]        s_seg_q, s_seg_d, p_seg_q, p_seg_d;
    logic [NDIG-1:0]   s_an_q, s_an_d, p_an_q, p_an_d;
    seg_scan_st_t      state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [4*NDIG-1:0] digits_q, digits_d;
    logic [NDIG-1:0]   valid_q, valid_d;
    logic              upd_q, upd_d, err_q, err_d;
    logic [7:0]        cur_pad_s, prev_pad_s;
    logic              same_s, cur_ok_s, capture_s;
    logic [2:0]        cap_idx_s;
    logic              pat_legal_s, pat_blank_s;
    logic [3:0]        pat_hex_s;
`ifdef SEG_SCAN_DP_EN
    logic              s_dp_q, s_dp_d, p_dp_q, p_dp_d;
    logic [NDIG-1:0]   dp_q, dp_d;
`endif

    // The previous sample is what gets captured, since it is the one the counter qualified.
    seg_pat_decode u_pat (
        .seg_i   (p_seg_q),
        .legal_o (pat_legal_s),
        .blank_o (pat_blank_s),
        .hex_o   (pat_hex_s)
    );

    // Sample pipeline and stability/capture qualifiers.
    always_comb begin
        s_seg_d    = seg_i;
        s_an_d     = an_i;
        p_seg_d    = s_seg_q;
        p_an_d     = s_an_q;
        cur_pad_s  = 8'hFF;
        cur_pad_s[NDIG-1:0]  = s_an_q;
        prev_pad_s = 8'hFF;
        prev_pad_s[NDIG-1:0] = p_an_q;
        same_s     = (s_seg_q == p_seg_q) && (s_an_q == p_an_q);
`ifdef SEG_SCAN_DP_EN
        s_dp_d     = dp_i;
        p_dp_d     = s_dp_q;
        same_s     = same_s && (s_dp_q == p_dp_q);
`endif
        cur_ok_s   = onehot_low_ok(cur_pad_s);
        cap_idx_s  = onehot_low_idx(prev_pad_s);
        capture_s  = (state_q == SETTLE) && (cnt_q == STABLE_CNT);
    end

    // Scan FSM; a sample change in the capture cycle restarts counting instead of holding.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (cur_ok_s) begin
                    state_d = SETTLE;
                    cnt_d   = 8'd1;
                end else begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end
            end
            SETTLE, HOLD: begin
                if (!same_s) begin
                    state_d = cur_ok_s ? SETTLE : IDLE;
                    cnt_d   = cur_ok_s ? 8'd1 : 8'd0;
                end else if (capture_s || (state_q == HOLD)) begin
                    state_d = HOLD;
                    cnt_d   = cnt_q;
                end else begin
                    state_d = SETTLE;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Per-digit register file update and change/error flags.
    always_comb begin
        digits_d = digits_q;
        valid_d  = valid_q;
        err_d    = err_q;
`ifdef SEG_SCAN_DP_EN
        dp_d     = dp_q;
`endif
        for (int d = 0; d < NDIG; d++) begin
            if (capture_s && (cap_idx_s == 3'(d))) begin
                if (pat_legal_s) begin
                    digits_d[4*d +: 4] = pat_hex_s;
                    valid_d[d]         = 1'b1;
                end else if (pat_blank_s) begin
                    valid_d[d]         = 1'b0;
                end else begin
                    valid_d[d]         = 1'b0;
                    err_d              = 1'b1;
                end
`ifdef SEG_SCAN_DP_EN
                dp_d[d] = (pat_legal_s || pat_blank_s) ? ~p_dp_q : dp_q[d];
`endif
            end else begin
                valid_d[d] = valid_d[d];
            end
        end
        upd_d = (digits_d != digits_q) || (valid_d != valid_q);
`ifdef SEG_SCAN_DP_EN
        upd_d = upd_d || (dp_d != dp_q);
`endif
    end

    // All state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_seg_q  <= SEG_BLANK;
            p_seg_q  <= SEG_BLANK;
            s_an_q   <= {NDIG{1'b1}};
            p_an_q   <= {NDIG{1'b1}};
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            digits_q <= {(4*NDIG){1'b0}};
            valid_q  <= {NDIG{1'b0}};
            upd_q    <= 1'b0;
            err_q    <= 1'b0;
`ifdef SEG_SCAN_DP_EN
            s_dp_q   <= 1'b1;
            p_dp_q   <= 1'b1;
            dp_q     <= {NDIG{1'b0}};
`endif
        end else begin
            s_seg_q  <= s_seg_d;
            p_seg_q  <= p_seg_d;
            s_an_q   <= s_an_d;
            p_an_q   <= p_an_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            valid_q  <= valid_d;
            upd_q    <= upd_d;
            err_q    <= err_d;
`ifdef SEG_SCAN_DP_EN
            s_dp_q   <= s_dp_d;
            p_dp_q   <= p_dp_d;
            dp_q     <= dp_d;
`endif
        end
    end

    assign digits_o = digits_q;
    assign valid_o  = valid_q;
    assign upd_o    = upd_q;
    assign err_o    = err_q;
`ifdef SEG_SCAN_DP_EN
    assign dp_o     = dp_q;
`endif

endmodule

// File: tb/tb_seg_scan_decode.sv
// Directed bench for seg_scan_decode (NDIG=4, STABLE_CYC=4) with a run-length reference model.
module tb_seg_scan_decode;

    localparam int NDIG       = 4;
    localparam int STABLE_CYC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_i;
    logic [3:0]  an_i;
    logic [15:0] digits_o;
    logic [3:0]  valid_o;
    logic        upd_o;
    logic        err_o;
`ifdef SEG_SCAN_DP_EN
    logic        dp_i = 1'b1;
    logic [3:0]  dp_o;
`endif

    int checks = 0;
    int errors = 0;
    int upd_cnt = 0;
    int base;

    // Active-high gfedcba segment table; the bus carries its complement.
    logic [6:0] hexa [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    seg_scan_decode #(.NDIG(NDIG), .STABLE_CYC(STABLE_CYC)) dut (
        .clk      (clk),
        .rst      (rst),
        .seg_i    (seg_i),
        .an_i     (an_i),
`ifdef SEG_SCAN_DP_EN
        .dp_i     (dp_i),
        .dp_o     (dp_o),
`endif
        .digits_o (digits_o),
        .valid_o  (valid_o),
        .upd_o    (upd_o),
        .err_o    (err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] pat(input int h);
        return ~hexa[h];
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [6:0] s, input logic [3:0] a, input int n);
        seg_i = s;
        an_i  = a;
        repeat (n) @(negedge clk);
    endtask

    // Reference model: a digit is captured two edges after the sample that completes
    // a run of exactly STABLE_CYC identical one-hot samples.
    logic        model_live = 1'b0;
    logic [15:0] exp_digits;
    logic [3:0]  exp_valid;
    logic        exp_upd, exp_err;
    int          run_len, p1_dig, p2_dig;
    logic        have_last, p1_v, p2_v;
    logic [6:0]  last_seg, p1_seg, p2_seg;
    logic [3:0]  last_an;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                model_live = 1'b1;
                exp_digits = 16'h0;
                exp_valid  = 4'h0;
                exp_upd    = 1'b0;
                exp_err    = 1'b0;
                run_len    = 0;
                have_last  = 1'b0;
                p1_v       = 1'b0;
                p2_v       = 1'b0;
            end else begin
                logic [15:0] od;
                logic [3:0]  ov;
                int          zeros, idx, hit;
                od = exp_digits;
                ov = exp_valid;
                if (p2_v) begin
                    hit = -1;
                    for (int h = 0; h < 16; h++) if (pat(h) == p2_seg) hit = h;
                    if (hit >= 0) begin
                        exp_digits[4*p2_dig +: 4] = 4'(hit);
                        exp_valid[p2_dig] = 1'b1;
                    end else begin
                        exp_valid[p2_dig] = 1'b0;
                        if (p2_seg != 7'h7F) exp_err = 1'b1;
                    end
                end
                exp_upd = (od != exp_digits) || (ov != exp_valid);
                p2_v   = p1_v;
                p2_seg = p1_seg;
                p2_dig = p1_dig;
                zeros = 0;
                idx   = 0;
                for (int i = 0; i < NDIG; i++) if (!an_i[i]) begin zeros++; idx = i; end
                if (zeros == 1)
                    run_len = (have_last && seg_i == last_seg && an_i == last_an) ? run_len + 1 : 1;
                else
                    run_len = 0;
                have_last = 1'b1;
                last_seg  = seg_i;
                last_an   = an_i;
                p1_v      = (run_len == STABLE_CYC);
                p1_seg    = seg_i;
                p1_dig    = idx;
            end
        end
    end

    // Cycle compare against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (upd_o === 1'b1) upd_cnt++;
            if (model_live) begin
                check("digits", 32'(digits_o), 32'(exp_digits));
                check("valid",  32'(valid_o),  32'(exp_valid));
                check("upd",    32'(upd_o),    32'(exp_upd));
                check("err",    32'(err_o),    32'(exp_err));
            end
        end
    end

    initial begin
        rst = 1'b1;
        drive(7'h00, 4'b1110, 2);
        check("t1_reset_digits", 32'(digits_o), 32'h0);
        check("t1_reset_valid",  32'(valid_o),  32'h0);
        check("t1_reset_flags",  32'({upd_o, err_o}), 32'h0);

        rst = 1'b0;
        drive(7'b0100100, 4'b1101, 5);
        check("t2_before_latency", 32'({upd_o, valid_o}), 32'h0);
        drive(7'b0100100, 4'b1101, 1);
        check("t2_upd_edge", 32'(upd_o), 32'h1);
        check("t2_digit1", 32'(digits_o[7:4]), 32'h2);
        check("t2_valid", 32'(valid_o), 32'h2);
        drive(7'b0100100, 4'b1101, 3);
        check("t2_single_pulse", 32'(upd_o), 32'h0);

        rst = 1'b1;
        drive(7'h7F, 4'hF, 1);
        rst = 1'b0;
        base = upd_cnt;
        for (int r = 0; r < 2; r++)
            for (int d = 0; d < 4; d++)
                drive(pat(d + 1), ~(4'b0001 << d), 8);
        check("t3_digits", 32'(digits_o), 32'h4321);
        check("t3_valid", 32'(valid_o), 32'hF);
        check("t3_pulses", 32'(upd_cnt - base), 32'd4);

        drive(7'b1000000, 4'b1110, 8);
        base = upd_cnt;
        drive(7'b1111001, 4'b1110, 3);
        drive(7'b1000000, 4'b1110, 8);
        check("t4_glitch_digits", 32'(digits_o), 32'h4320);
        check("t4_glitch_pulses", 32'(upd_cnt - base), 32'd0);

        drive(7'b0101010, 4'b1101, 5);
        drive(7'h7F, 4'b1011, 6);
        check("t5_valid", 32'(valid_o), 32'h9);
        check("t5_err", 32'(err_o), 32'h1);
        check("t5_digits_kept", 32'(digits_o), 32'h4320);
        drive(pat(5), 4'b1101, 7);
        check("t5_err_sticky", 32'(err_o), 32'h1);
        check("t5_recover", 32'({digits_o, valid_o}), 32'h4350B);

        base = upd_cnt;
        drive(7'h00, 4'b1100, 10);
        check("t6_no_capture", 32'({digits_o, valid_o}), 32'h4350B);
        check("t6_no_pulse", 32'(upd_cnt - base), 32'd0);
        drive(7'h00, 4'b0111, 3);
        rst = 1'b1;
        drive(7'h00, 4'b0111, 1);
        check("t6_rst_digits", 32'(digits_o), 32'h0);
        check("t6_rst_flags", 32'({valid_o, upd_o, err_o}), 32'h0);
        rst = 1'b0;
        drive(7'h7F, 4'hF, 4);
        check("t6_partial_dropped", 32'({digits_o, valid_o}), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
